// File: rtl/ram_dma_burst_wr_ctrl.sv
// Drains FIFO words into an asynchronous byte-wide SRAM, one RAM lane at a time.
// Every output is a flop whose next value is decoded from the next state, so the strobes
// change cleanly on the clock edge.
// The write pointer walks a circular region. base_addr and region_size are used live
// whenever an address is computed.
//
// state         | meaning
// --------------+---------------------------------------------------------------
// IDLE          | waiting for a valid head word while wr_enable is high
// WR_START      | chip enable asserted, bus still parked at 0
// WR_PLACE_ADDR | address driven to the RAM
// WR_PLACE_DATA | address and lane data driven
// WR_BYTE       | write strobe low; held here while the RAM reports busy
// DONE          | chip enable released; advance the lane and offset, pop after the last lane
module ram_dma_burst_wr_ctrl #(
    parameter  int WORD_WIDTH     = 32,
    parameter  int RAM_DATA_WIDTH = 8,
    parameter  int RAM_ADDR_WIDTH = 16,
    parameter  int LANE_ORDER     = 0,
    localparam int LANES          = WORD_WIDTH / RAM_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WORD_WIDTH-1:0]     fifo_data_out,
    input  logic                      fifo_data_out_vld,
    output logic                      fifo_data_pop,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr_l,
    output logic                      CE_bar_l,
    output logic                      RW_bar_l,
    output logic                      OE_bar_l,
    input  logic                      BUSY_bar_l,
    output logic [RAM_DATA_WIDTH-1:0] ram_wr_data,
    input  logic                      wr_enable,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [RAM_ADDR_WIDTH-1:0] region_size,
    input  logic                      batch_done,
    output logic [RAM_ADDR_WIDTH-1:0] words_written,
    output logic                      wrap_pulse,
    output logic                      busy
);

    localparam int                        LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0]             LAST_LANE = LW'(LANES - 1);
    localparam logic [LW-1:0]             LANE_ONE  = LW'(1);
    localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE  = RAM_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR_START,
        WR_PLACE_ADDR,
        WR_PLACE_DATA,
        WR_BYTE,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [RAM_ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [RAM_ADDR_WIDTH-1:0] words_written_q, words_written_d;
    logic                      pend_q, pend_d;
    logic [WORD_WIDTH-1:0]     word_q, word_d;
    logic                      ce_bar_q, ce_bar_d;
    logic                      rw_bar_q, rw_bar_d;
    logic                      pop_q, pop_d;
    logic                      wrap_q, wrap_d;
    logic                      busy_q, busy_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RAM_DATA_WIDTH-1:0] data_q, data_d;

    logic [LW-1:0]             lane_sel;
    logic [RAM_DATA_WIDTH-1:0] lane_data;
    logic                      lane_is_last;
    logic                      wrap_hit;
    logic [RAM_ADDR_WIDTH-1:0] offset_nxt;

    // A region_size of 0 makes region_size-1 all ones, which gives the natural 2^N wrap.
    assign lane_sel     = (LANE_ORDER != 0) ? (LAST_LANE - lane_q) : lane_q;
    assign lane_data    = word_q[lane_sel*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
    assign lane_is_last = (lane_q == LAST_LANE);
    assign wrap_hit     = (offset_q == (region_size - ADDR_ONE));
    assign offset_nxt   = wrap_hit ? '0 : (offset_q + ADDR_ONE);

    // Next-state, pointer bookkeeping and registered-output decode.
    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        offset_d        = offset_q;
        words_written_d = words_written_q;
        pend_d          = pend_q;
        word_d          = word_q;

        // A rewind requested mid-word is deferred so that the word in flight completes.
        if (batch_done && (state_q != IDLE)) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (batch_done) begin
                    offset_d        = '0;
                    words_written_d = '0;
                end
                if (fifo_data_out_vld && wr_enable) begin
                    word_d  = fifo_data_out;
                    lane_d  = '0;
                    state_d = WR_START;
                end
            end
            WR_START:      state_d = WR_PLACE_ADDR;
            WR_PLACE_ADDR: state_d = WR_PLACE_DATA;
            WR_PLACE_DATA: state_d = WR_BYTE;
            WR_BYTE:       if (BUSY_bar_l) state_d = DONE;
            DONE: begin
                if (lane_is_last) begin
                    state_d = IDLE;
                    lane_d  = '0;
                    if (pend_q || batch_done) begin
                        offset_d        = '0;
                        words_written_d = '0;
                        pend_d          = 1'b0;
                    end else begin
                        offset_d        = offset_nxt;
                        words_written_d = words_written_q + ADDR_ONE;
                    end
                end else begin
                    state_d  = WR_START;
                    lane_d   = lane_q + LANE_ONE;
                    offset_d = offset_nxt;
                end
            end
            default: state_d = IDLE;
        endcase

        ce_bar_d = !(state_d inside {WR_START, WR_PLACE_ADDR, WR_PLACE_DATA, WR_BYTE});
        rw_bar_d = !(state_d inside {WR_BYTE, DONE});
        addr_d   = (state_d inside {WR_PLACE_ADDR, WR_PLACE_DATA, WR_BYTE, DONE})
                   ? (base_addr + offset_q) : '0;
        data_d   = (state_d inside {WR_PLACE_DATA, WR_BYTE, DONE}) ? lane_data : '0;
        pop_d    = (state_q == WR_BYTE) && BUSY_bar_l && lane_is_last;
        wrap_d   = (state_q == WR_BYTE) && BUSY_bar_l && wrap_hit;
        busy_d   = (state_d != IDLE);
    end

    // State, datapath and output registers; reset parks every output in its idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            lane_q          <= '0;
            offset_q        <= '0;
            words_written_q <= '0;
            pend_q          <= 1'b0;
            word_q          <= '0;
            ce_bar_q        <= 1'b1;
            rw_bar_q        <= 1'b1;
            pop_q           <= 1'b0;
            wrap_q          <= 1'b0;
            busy_q          <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
        end else begin
            state_q         <= state_d;
            lane_q          <= lane_d;
            offset_q        <= offset_d;
            words_written_q <= words_written_d;
            pend_q          <= pend_d;
            word_q          <= word_d;
            ce_bar_q        <= ce_bar_d;
            rw_bar_q        <= rw_bar_d;
            pop_q           <= pop_d;
            wrap_q          <= wrap_d;
            busy_q          <= busy_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
        end
    end

    assign fifo_data_pop = pop_q;
    assign ram_wr_addr_l = addr_q;
    assign ram_wr_data   = data_q;
    assign CE_bar_l      = ce_bar_q;
    assign RW_bar_l      = rw_bar_q;
    assign OE_bar_l      = 1'b1;
    assign words_written = words_written_q;
    assign wrap_pulse    = wrap_q;
    assign busy          = busy_q;

endmodule
